vc_test_fixed_delay_source: RTL and testbench

//  Bench-side message source. Drives val/rdy stream into DUT, whose output feeds vc test sinks.

---
 rtl/vc_test_pkg.sv | 11 +
 rtl/vc_test_delay_counter.sv | 29 ++
 rtl/vc_test_fixed_delay_source.sv | 82 ++++++++
 tb/tb_vc_test_fixed_delay_source.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vc_test_pkg.sv
// Shared types for the vc test source: source FSM encoding and delay counter width.
package vc_test_pkg;

  typedef enum logic {
    VC_SRC_RUN  = 1'b0,
    VC_SRC_DONE = 1'b1
  } vc_src_state_t;

  localparam int VC_TEST_DELAY_NBITS = 32;

endpackage

// File: rtl/vc_test_delay_counter.sv
// Idle-cycle counter for the fixed delay source: clears on handshake, saturates at delay.
module vc_test_delay_counter
  import vc_test_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           clear,
  input  logic [VC_TEST_DELAY_NBITS-1:0] delay,
  output logic                           ready
);

  logic [VC_TEST_DELAY_NBITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      if (clear)
        cnt <= '0;
      else if (cnt < delay)
        cnt <= cnt + 1'b1;
    end
  end

  // Live compare so a lowered delay releases the wait immediately.
  assign ready = (cnt >= delay);

endmodule

// File: rtl/vc_test_fixed_delay_source.sv
// Val/rdy message source with a fixed idle gap before every message.
// Define VC_TEST_FIXED_DELAY_SOURCE_TRACE_EN to print each handshake and the end of stream.
module vc_test_fixed_delay_source
  import vc_test_pkg::*;
#(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs  = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [VC_TEST_DELAY_NBITS-1:0] delay,
  output logic                           val,
  input  logic                           rdy,
  output logic [p_msg_nbits-1:0]         msg,
  output logic                           done
);

  localparam int c_idx_nbits = $clog2(p_num_msgs + 1);
  localparam int c_rd_nbits  = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [c_idx_nbits-1:0] c_end_idx = c_idx_nbits'(p_num_msgs);

  // Loaded hierarchically by the bench before reset is released.
  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

  vc_src_state_t          state;
  logic [c_idx_nbits-1:0] idx;
  logic [c_rd_nbits-1:0]  rd_idx;
  logic                   at_end;
  logic                   empty;
  logic                   gap_done;
  logic                   xfer;

  function automatic logic all_x(input logic [p_msg_nbits-1:0] v);
    all_x = 1'b1;
    for (int i = 0; i < p_msg_nbits; i++)
      if (!$isunknown(v[i])) all_x = 1'b0;
  endfunction

  assign rd_idx = idx[c_rd_nbits-1:0];
  assign at_end = (idx == c_end_idx);
  assign msg    = m[rd_idx];

  // An all-X entry marks a short stream inside a larger array.
  always_comb begin
    empty = at_end;
    if (!at_end && all_x(m[rd_idx])) empty = 1'b1;
  end

  assign val  = (state == VC_SRC_RUN) && !empty && gap_done;
  assign xfer = val && rdy;
  assign done = (state == VC_SRC_DONE);

  vc_test_delay_counter u_delay_counter (
    .clk   (clk),
    .reset (reset),
    .en    (state == VC_SRC_RUN),
    .clear (xfer),
    .delay (delay),
    .ready (gap_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= VC_SRC_RUN;
      idx   <= '0;
    end else if (state == VC_SRC_RUN) begin
      if (xfer) idx <= idx + 1'b1;
      if (empty) state <= VC_SRC_DONE;
    end
  end

`ifdef VC_TEST_FIXED_DELAY_SOURCE_TRACE_EN
  always @(posedge clk) begin
    if (reset && state == VC_SRC_RUN) begin
      if (xfer) $display("src: idx=%0d msg=%h t=%0t", idx, msg, $time);
      if (empty) $display("src: done n=%0d", idx);
    end
  end
`else
`endif

endmodule

// File: tb/tb_vc_test_fixed_delay_source.sv
// Self-checking bench: three source instances of different depth, scoreboarded messages.
module tb_vc_test_fixed_delay_source;
  import vc_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3 = 1'b0, rst2 = 1'b0, rst4 = 1'b0;
  logic [31:0] dly3 = 0, dly2 = 0, dly4 = 0;
  logic        rdy3 = 1'b0, rdy2 = 1'b0, rdy4 = 1'b0;
  logic        val3, val2, val4;
  logic        done3, done2, done4;
  logic [7:0]  msg3, msg2, msg4;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  vc_test_fixed_delay_source #(.p_msg_nbits(8), .p_num_msgs(3)) dut3 (
    .clk(clk), .reset(rst3), .delay(dly3), .val(val3), .rdy(rdy3), .msg(msg3), .done(done3));
  vc_test_fixed_delay_source #(.p_msg_nbits(8), .p_num_msgs(2)) dut2 (
    .clk(clk), .reset(rst2), .delay(dly2), .val(val2), .rdy(rdy2), .msg(msg2), .done(done2));
  vc_test_fixed_delay_source #(.p_msg_nbits(8), .p_num_msgs(4)) dut4 (
    .clk(clk), .reset(rst4), .delay(dly4), .val(val4), .rdy(rdy4), .msg(msg4), .done(done4));

  task automatic test_reset();
    dut3.m[0] = 8'h01; dut3.m[1] = 8'h02; dut3.m[2] = 8'h03;
    dut2.m[0] = 8'h11; dut2.m[1] = 8'h22;
    dut4.m[0] = 8'h0A; dut4.m[1] = 8'h0B; dut4.m[2] = 8'h0C; dut4.m[3] = 8'h0D;
    dly3 = 0; dly2 = 3; dly4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3 got=%b exp=0", done3); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done2 got=%b exp=0", done2); end
    checks++; if (val2 !== 1'b0) begin errors++; $display("FAIL reset_val_delay3 got=%b exp=0", val2); end
    checks++; if (val3 !== 1'b1) begin errors++; $display("FAIL reset_val_delay0 got=%b exp=1", val3); end
    checks++; if (msg4 !== 8'h0A) begin errors++; $display("FAIL reset_msg got=%h exp=0a", msg4); end
  endtask

  task automatic test_zero_delay();
    exp_q = {8'h01, 8'h02, 8'h03};
    rdy3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (val3 !== (k < 3)) begin errors++; $display("FAIL zd_val k=%0d got=%b exp=%b", k, val3, (k < 3)); end
      if (val3 && rdy3) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL zd_extra k=%0d got=%h exp=none", k, msg3); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (msg3 !== e) begin errors++; $display("FAIL zd_msg k=%0d got=%h exp=%h", k, msg3, e); end
        end
      end
      if (k >= 4) begin
        checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL zd_done k=%0d got=%b exp=1", k, done3); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zd_left got=%0d exp=0", exp_q.size()); end
    rst3 = 1'b0;
  endtask

  task automatic test_fixed_delay();
    exp_q = {8'h11, 8'h22};
    rdy2 = 1'b1;
    @(posedge clk); #1 rst2 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++;
      if (val2 !== (k == 3 || k == 7)) begin
        errors++; $display("FAIL fd_val k=%0d got=%b exp=%b", k, val2, (k == 3 || k == 7));
      end
      if (val2 && rdy2) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fd_extra k=%0d got=%h exp=none", k, msg2); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (msg2 !== e) begin errors++; $display("FAIL fd_msg k=%0d got=%h exp=%h", k, msg2, e); end
        end
      end
      if (k == 7 || k >= 9) begin
        checks++;
        if (done2 !== (k >= 9)) begin errors++; $display("FAIL fd_done k=%0d got=%b exp=%b", k, done2, (k >= 9)); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fd_left got=%0d exp=0", exp_q.size()); end
    rst2 = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_q = {8'h0A};
    dly4 = 0; rdy4 = 1'b0;
    @(posedge clk); #1 rst4 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) rdy4 = 1'b1;
      if (k == 6) rdy4 = 1'b0;
      @(negedge clk);
      checks++;
      if (val4 !== 1'b1) begin errors++; $display("FAIL bp_val k=%0d got=%b exp=1", k, val4); end
      if (k < 5) begin
        checks++; if (msg4 !== 8'h0A) begin errors++; $display("FAIL bp_hold k=%0d got=%h exp=0a", k, msg4); end
      end
      if (k == 6) begin
        checks++; if (msg4 !== 8'h0B) begin errors++; $display("FAIL bp_next got=%h exp=0b", msg4); end
      end
      if (val4 && rdy4) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra k=%0d got=%h exp=none", k, msg4); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (msg4 !== e) begin errors++; $display("FAIL bp_msg k=%0d got=%h exp=%h", k, msg4, e); end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_stream();
    exp_q = {8'h0A, 8'h0B, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    rst4 = 1'b0; rdy4 = 1'b0;
    @(posedge clk); #1 rst4 = 1'b1; rdy4 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin rst4 = 1'b0; rdy4 = 1'b0; end
      if (k == 3) begin rst4 = 1'b1; rdy4 = 1'b1; end
      @(negedge clk);
      if (val4 && rdy4) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_extra k=%0d got=%h exp=none", k, msg4); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (msg4 !== e) begin errors++; $display("FAIL rm_msg k=%0d got=%h exp=%h", k, msg4, e); end
        end
      end
      checks++;
      if (done4 !== (k >= 8)) begin errors++; $display("FAIL rm_done k=%0d got=%b exp=%b", k, done4, (k >= 8)); end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_full_array();
    int hs = 0;
    exp_q = {8'h0A, 8'h0B, 8'h0C, 8'h0D};
    rst4 = 1'b0; dly4 = 1; rdy4 = 1'b1;
    @(posedge clk); #1 rst4 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (val4 !== (k == 1 || k == 3 || k == 5 || k == 7)) begin
        errors++; $display("FAIL fa_val k=%0d got=%b exp=%b", k, val4, (k == 1 || k == 3 || k == 5 || k == 7));
      end
      if (val4 && rdy4) begin
        hs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fa_extra k=%0d got=%h exp=none", k, msg4); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (msg4 !== e) begin errors++; $display("FAIL fa_msg k=%0d got=%h exp=%h", k, msg4, e); end
        end
      end
      if (k >= 9) begin
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL fa_done k=%0d got=%b exp=1", k, done4); end
      end
      @(posedge clk); #1;
    end
    checks++; if (hs != 4) begin errors++; $display("FAIL fa_handshakes got=%0d exp=4", hs); end
    checks++; if (dut4.idx !== 3'd4) begin errors++; $display("FAIL fa_idx got=%0d exp=4", dut4.idx); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fa_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_fixed_delay();
    test_backpressure();
    test_reset_mid_stream();
    test_full_array();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
